// File: rtl/command_receiver_pkg.sv
// Shared types and constants for the command_receiver byte-stream framer.
package command_receiver_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PARAM = 1'b1
    } state_e;

    localparam int PARAM_FLAG_BIT = 7;
    localparam int PARAM_BYTES    = 4;
    localparam int OPCODE_W       = 8;
    localparam int PARAM_W        = 32;

    typedef logic [$clog2(PARAM_BYTES)-1:0] byte_idx_t;

endpackage : command_receiver_pkg

// File: rtl/command_receiver_if.sv
// Byte stream in, framed command out. The framer uses the slave modport,
// the byte source / command consumer side uses the master modport.
interface command_receiver_if;
    import command_receiver_pkg::*;

    logic [7:0]          serial_input_data;
    logic                serial_input_valid;
    logic [OPCODE_W-1:0] command;
    logic [PARAM_W-1:0]  param;
    logic                command_valid;

    modport slave (
        input  serial_input_data,
        input  serial_input_valid,
        output command,
        output param,
        output command_valid
    );

    modport master (
        output serial_input_data,
        output serial_input_valid,
        input  command,
        input  param,
        input  command_valid
    );
endinterface : command_receiver_if

// File: rtl/command_timeout_counter.sv
// Idle-cycle counter with clear priority. expired_o flags the increment that
// would make the count reach LIMIT, so the caller can act on that same edge.
module command_timeout_counter #(
    parameter int LIMIT = 65536
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; count only needs to reach LIMIT-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 1'b1;
    end

    assign expired_o = inc_i && !clear_i && (cnt_q == CNT_W'(LIMIT - 1));

    // Counter register.
    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule : command_timeout_counter

// File: rtl/command_receiver.sv
// Frames a byte stream into commands: opcode byte, plus a 32-bit LE parameter
// when opcode bit 7 is set. Completed commands appear as a one-cycle pulse.
// Optional partial-frame timeout: define COMMAND_RECEIVER_TIMEOUT_EN.
module command_receiver
    import command_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic               clock,
    input  logic               reset,
    command_receiver_if.slave  bus
);
    state_e              state_q, state_d;
    byte_idx_t           idx_q, idx_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [PARAM_W-1:0]  asm_q, asm_d;
    logic [OPCODE_W-1:0] command_q, command_d;
    logic [PARAM_W-1:0]  param_q, param_d;
    logic                valid_q, valid_d;
    logic                timeout;

`ifdef COMMAND_RECEIVER_TIMEOUT_EN
    // Count idle cycles only while a long frame is partially received.
    command_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear_i  ((state_q != PARAM) || bus.serial_input_valid),
        .inc_i    ((state_q == PARAM) && !bus.serial_input_valid),
        .expired_o(timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Next-state and output-register logic for the framing FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opcode_d  = opcode_q;
        asm_d     = asm_q;
        command_d = command_q;
        param_d   = param_q;
        valid_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.serial_input_valid) begin
                    opcode_d = bus.serial_input_data;
                    if (bus.serial_input_data[PARAM_FLAG_BIT]) begin
                        state_d = PARAM;
                        idx_d   = '0;
                    end else begin
                        command_d = bus.serial_input_data;
                        param_d   = '0;
                        valid_d   = 1'b1;
                    end
                end
            end
            PARAM: begin
                if (bus.serial_input_valid) begin
                    // Any byte value is data here, bit 7 included.
                    asm_d[{idx_q, 3'b000} +: 8] = bus.serial_input_data;
                    if (idx_q == byte_idx_t'(PARAM_BYTES - 1)) begin
                        command_d = opcode_q;
                        param_d   = asm_d;
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timeout) begin
                    // Abandon the partial frame silently; outputs keep last command.
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset beats a simultaneous byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            opcode_q  <= '0;
            asm_q     <= '0;
            command_q <= '0;
            param_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opcode_q  <= opcode_d;
            asm_q     <= asm_d;
            command_q <= command_d;
            param_q   <= param_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.command       = command_q;
    assign bus.param         = param_q;
    assign bus.command_valid = valid_q;
endmodule : command_receiver

// File: tb/tb_command_receiver.sv
// Scoreboard bench for command_receiver: the driver queues the expected
// command when it issues a frame's final byte; a monitor checks every pulse.
module tb_command_receiver;
    import command_receiver_pkg::*;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] prm;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t expq[$];

    always #5 clock = ~clock;

    command_receiver_if bus ();

    command_receiver #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one byte for one edge; inputs change 1 time unit after the edge.
    task automatic send(input logic [7:0] b);
        bus.serial_input_data  = b;
        bus.serial_input_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.serial_input_valid = 1'b0;
    endtask

    task automatic expect_cmd(input logic [7:0] c, input logic [31:0] p);
        exp_t e;
        e.cmd = c;
        e.prm = p;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && bus.command_valid !== 1'b0) begin
            if (expq.size() == 0) begin
                check("unexpected_pulse", {24'h0, bus.command}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("pulse_command", {24'h0, bus.command}, {24'h0, e.cmd});
                check("pulse_param", bus.param, e.prm);
            end
        end
    end

    initial begin
        bus.serial_input_data  = 8'h00;
        bus.serial_input_valid = 1'b0;
        idle(3);
        @(negedge clock);
        check("reset_command", {24'h0, bus.command}, 32'h0);
        check("reset_param", bus.param, 32'h0);
        check("reset_valid", {31'h0, bus.command_valid}, 32'h0);
        reset = 1'b0;
        idle(2);

        // Short command.
        expect_cmd(8'h03, 32'h0);
        send(8'h03);
        idle(3);

        // Long command.
        send(8'h84); send(8'h01); send(8'h02); send(8'h03);
        expect_cmd(8'h84, 32'h0403_0201);
        send(8'h04);
        idle(4);
        @(negedge clock);
        check("hold_command", {24'h0, bus.command}, 32'h84);
        check("hold_param", bus.param, 32'h0403_0201);
        check("hold_valid_low", {31'h0, bus.command_valid}, 32'h0);
        idle(1);

        // Parameter bytes with bit 7 set are data, followed directly by a short.
        send(8'h81); send(8'hFF); send(8'h80); send(8'h00);
        expect_cmd(8'h81, 32'h7F00_80FF);
        send(8'h7F);
        expect_cmd(8'h10, 32'h0);
        send(8'h10);
        idle(2);

        // Back-to-back short commands.
        expect_cmd(8'h05, 32'h0);
        send(8'h05);
        expect_cmd(8'h06, 32'h0);
        send(8'h06);
        idle(2);

        // Short after long on consecutive cycles clears param to 0.
        send(8'hC0); send(8'h11); send(8'h22); send(8'h33);
        expect_cmd(8'hC0, 32'h4433_2211);
        send(8'h44);
        expect_cmd(8'h7F, 32'h0);
        send(8'h7F);
        idle(2);

        // Reset mid-frame discards the partial frame.
        send(8'h84); send(8'h01);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_command", {24'h0, bus.command}, 32'h0);
        check("midreset_param", bus.param, 32'h0);
        expect_cmd(8'h02, 32'h0);
        send(8'h02);
        idle(2);

        // Reset wins over a simultaneous valid byte.
        reset = 1'b1;
        send(8'h05);
        reset = 1'b0;
        idle(3);

`ifdef COMMAND_RECEIVER_TIMEOUT_EN
        // Seven idle cycles: frame survives.
        send(8'h84); send(8'h01);
        idle(7);
        send(8'h02); send(8'h03);
        expect_cmd(8'h84, 32'h0403_0201);
        send(8'h04);
        idle(2);
        // Eight idle cycles: frame abandoned, next byte is an opcode.
        send(8'h84); send(8'h01);
        idle(8);
        expect_cmd(8'h07, 32'h0);
        send(8'h07);
        idle(2);
`else
        // Without the timeout a partial frame waits indefinitely.
        send(8'h84); send(8'h01);
        idle(40);
        send(8'h02); send(8'h03);
        expect_cmd(8'h84, 32'h0403_0201);
        send(8'h04);
        idle(2);
`endif

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 20 && expq.size() != 0; i++) @(posedge clock);
        check("scoreboard_empty", expq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule : tb_command_receiver
